// File: rtl/phy_mem_ctrl_if.sv
// CPU physical-memory (dev_mem_*) bus between the MMU side and the SRAM controller.
// The master modport is the CPU side. The slave modport is the memory responder.
interface phy_mem_ctrl_if;
  logic [31:0] dev_mem_addr;
  logic [31:0] dev_mem_data_out;
  logic        dev_mem_is_write;
  logic [31:0] dev_mem_data_in;
  logic        dev_mem_busy;

  modport master (
    output dev_mem_addr,
    output dev_mem_data_out,
    output dev_mem_is_write,
    input  dev_mem_data_in,
    input  dev_mem_busy
  );

  modport slave (
    input  dev_mem_addr,
    input  dev_mem_data_out,
    input  dev_mem_is_write,
    output dev_mem_data_in,
    output dev_mem_busy
  );
endinterface

// File: rtl/phy_mem_ctrl.sv
// Responder for CPU physical-memory accesses, driving an asynchronous 32-bit SRAM.
// Optional macro LAST_READ_CACHE_EN skips the SRAM for a repeat of the last completed read.
module phy_mem_ctrl #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 3,
  parameter int unsigned SRAM_AW   = 20
) (
  input  logic               clk,
  input  logic               rst,
  phy_mem_ctrl_if.slave      dev_mem,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_data_i,
  output logic [31:0]        sram_data_o,
  output logic               sram_data_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int unsigned CntMax = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StOor,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                acc_wr_q, acc_wr_d;
  logic [31:0]         data_in_q, data_in_d;
  logic                busy_q;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [31:0]         sram_data_q, sram_data_d;
  logic                data_oe_q, data_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;

  logic [SRAM_AW-1:0]  word_addr;
  logic                oor;
  logic                cache_hit;
  logic                rd_done;
  logic [1:0]          unused_byte_sel;

  assign word_addr       = dev_mem.dev_mem_addr[SRAM_AW+1:2];
  assign unused_byte_sel = dev_mem.dev_mem_addr[1:0];
  assign rd_done         = (state_q == StRead) && (cnt_q == CntW'(1));

  // Any address bit above the SRAM window makes the access out-of-range.
  if (SRAM_AW + 2 < 32) begin : g_range
    assign oor = |dev_mem.dev_mem_addr[31:SRAM_AW+2];
  end else begin : g_full_range
    assign oor = 1'b0;
  end

`ifdef LAST_READ_CACHE_EN
  logic               hit_valid_q, hit_valid_d;
  logic [SRAM_AW-1:0] hit_tag_q, hit_tag_d;

  assign cache_hit = hit_valid_q && (hit_tag_q == word_addr);

  // Writes and out-of-range accesses invalidate. The tag follows the last completed SRAM read.
  always_comb begin
    hit_valid_d = hit_valid_q;
    hit_tag_d   = hit_tag_q;
    if ((state_q == StIdle) && (dev_mem.dev_mem_is_write || oor)) begin
      hit_valid_d = 1'b0;
    end else if (rd_done) begin
      hit_valid_d = 1'b1;
      hit_tag_d   = sram_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_valid_q <= 1'b0;
      hit_tag_q   <= '0;
    end else begin
      hit_valid_q <= hit_valid_d;
      hit_tag_q   <= hit_tag_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_wr_d    = acc_wr_q;
    data_in_d   = data_in_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    unique case (state_q)
      StIdle: begin
        acc_wr_d = dev_mem.dev_mem_is_write;
        if (oor) begin
          state_d = StOor;
        end else if (dev_mem.dev_mem_is_write) begin
          state_d     = StWrSetup;
          sram_addr_d = word_addr;
          sram_data_d = dev_mem.dev_mem_data_out;
        end else if (!cache_hit) begin
          state_d     = StRead;
          cnt_d       = CntW'(RD_CYCLES);
          sram_addr_d = word_addr;
        end
      end
      StRead: begin
        if (rd_done) begin
          state_d   = StIdle;
          data_in_d = sram_data_i;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StOor: begin
        state_d = StIdle;
        if (!acc_wr_q) begin
          data_in_d = '0;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = CntW'(WR_CYCLES);
      end
      StWrPulse: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrHold: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    data_oe_d = 1'b0;
    unique case (state_d)
      StRead: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      StWrSetup, StWrHold: begin
        ce_n_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      StWrPulse: begin
        ce_n_d    = 1'b0;
        we_n_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_wr_q    <= 1'b0;
      data_in_q   <= '0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      data_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_wr_q    <= acc_wr_d;
      data_in_q   <= data_in_d;
      busy_q      <= (state_d != StIdle);
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      data_oe_q   <= data_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign dev_mem.dev_mem_data_in = data_in_q;
  assign dev_mem.dev_mem_busy    = busy_q;
  assign sram_addr               = sram_addr_q;
  assign sram_data_o             = sram_data_q;
  assign sram_data_oe            = data_oe_q;
  assign sram_ce_n               = ce_n_q;
  assign sram_oe_n               = oe_n_q;
  assign sram_we_n               = we_n_q;

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Scoreboarded random bench for phy_mem_ctrl against a behavioural SRAM and access model.
// Build with LAST_READ_CACHE_EN defined to expect the last-read cache behaviour.
module tb_phy_mem_ctrl;
  localparam int unsigned RD = 2;
  localparam int unsigned WR = 3;
  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phy_mem_ctrl_if bus ();

  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data_i, sram_data_o;
  logic          sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;

  phy_mem_ctrl #(
    .RD_CYCLES(RD),
    .WR_CYCLES(WR),
    .SRAM_AW  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_mem     (bus),
    .sram_addr   (sram_addr),
    .sram_data_i (sram_data_i),
    .sram_data_o (sram_data_o),
    .sram_data_oe(sram_data_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  // Asynchronous SRAM pin model: reads while CE/OE low, commits a write on the WE_n rising edge.
  logic [31:0] sram_mem [0:1023];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'h0;
  always @(posedge sram_we_n) if (rst) sram_mem[sram_addr[9:0]] <= sram_data_o;

  typedef struct {
    int          id;
    logic [31:0] data_in;
    int          busy;
    logic [31:0] ce_mask;
    logic [31:0] oe_mask;
    logic [31:0] we_mask;
    logic [31:0] doe_mask;
    logic [AW-1:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_id  = 0;

  // Reference model state.
  logic [31:0]   ref_mem [0:1023];
  logic [31:0]   m_data_in;
  bit            m_valid;
  logic [AW-1:0] m_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data, input bit wr);
    exp_t e;
    logic [AW-1:0] wa;
    bit is_oor;
    wa         = addr[AW+1:2];
    is_oor     = (addr[31:AW+2] != '0);
    e.id       = acc_id;
    e.wa       = wa;
    e.wd       = data;
    e.oe_mask  = 0;
    e.we_mask  = 0;
    e.doe_mask = 0;
    if (is_oor) begin
      e.busy = 1;
      if (!wr) m_data_in = 0;
      m_valid = 0;
    end else if (wr) begin
      e.busy     = WR + 2;
      e.we_mask  = ((1 << WR) - 1) << 1;
      e.doe_mask = (1 << (WR + 2)) - 1;
      ref_mem[wa[9:0]] = data;
      m_valid = 0;
    end
`ifdef LAST_READ_CACHE_EN
    else if (m_valid && m_tag == wa) begin
      e.busy = 0;
    end
`endif
    else begin
      e.busy    = RD;
      e.oe_mask = (1 << RD) - 1;
      m_data_in = ref_mem[wa[9:0]];
      m_valid   = 1;
      m_tag     = wa;
    end
    e.ce_mask = is_oor ? 32'h0 : (1 << e.busy) - 1;
    e.data_in = m_data_in;
    return e;
  endfunction

  // Called just after a falling edge; the access is accepted on the next rising edge.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] data, input bit wr);
    int guard = 0;
    while (bus.dev_mem_busy !== 1'b0) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL acc%0d accept_wait: got busy=%b expected 0", acc_id, bus.dev_mem_busy);
        return;
      end
    end
    bus.dev_mem_addr     = addr;
    bus.dev_mem_data_out = data;
    bus.dev_mem_is_write = wr;
    exp_q.push_back(model(addr, data, wr));
    acc_id++;
    @(negedge clk);
    #1;
  endtask

  // Monitor: follows each accepted access until busy drops, then scores it.
  initial begin
    exp_t        cur;
    bit          in_flight;
    int          bc;
    logic [31:0] cem, oem, wem, doem;
    logic [31:0] bad;
    in_flight = 0;
    bc = 0;
    cem = 0; oem = 0; wem = 0; doem = 0; bad = 0;
    forever begin
      @(posedge clk);
      if (rst && !in_flight && exp_q.size() > 0) begin
        in_flight = 1;
        cur = exp_q[0];
        bc = 0;
        cem = 0; oem = 0; wem = 0; doem = 0; bad = 0;
      end
      @(negedge clk);
      if (!rst) begin
        in_flight = 0;
        exp_q.delete();
      end else if (in_flight) begin
        if (bus.dev_mem_busy === 1'b1) begin
          if (bc < 32) begin
            cem[bc]  = !sram_ce_n;
            oem[bc]  = !sram_oe_n;
            wem[bc]  = !sram_we_n;
            doem[bc] = sram_data_oe;
          end
          if (!sram_ce_n && sram_addr !== cur.wa) bad[0] = 1'b1;
          if (sram_data_oe && sram_data_o !== cur.wd) bad[1] = 1'b1;
          if (!sram_oe_n && sram_data_oe) bad[2] = 1'b1;
          bc++;
          if (bc > 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL acc%0d busy_bound: got busy for %0d cycles", cur.id, bc);
            in_flight = 0;
            void'(exp_q.pop_front());
          end
        end else begin
          void'(exp_q.pop_front());
          check($sformatf("acc%0d data_in", cur.id), bus.dev_mem_data_in, cur.data_in);
          check($sformatf("acc%0d busy_cycles", cur.id), 32'(bc), 32'(cur.busy));
          check($sformatf("acc%0d ce_pattern", cur.id), cem, cur.ce_mask);
          check($sformatf("acc%0d oe_pattern", cur.id), oem, cur.oe_mask);
          check($sformatf("acc%0d we_pattern", cur.id), wem, cur.we_mask);
          check($sformatf("acc%0d data_oe_pattern", cur.id), doem, cur.doe_mask);
          check($sformatf("acc%0d addr_data_bus_rules", cur.id), bad, 32'h0);
          check($sformatf("acc%0d idle_strobes", cur.id),
                {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'he);
          in_flight = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    bit          w;
    int          guard;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[4] = 32'h12345678;
    ref_mem[4]  = 32'h12345678;
    m_data_in = 0;
    m_valid   = 0;
    m_tag     = '0;
    bus.dev_mem_addr     = 32'h10;
    bus.dev_mem_data_out = 32'h0;
    bus.dev_mem_is_write = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", {31'h0, bus.dev_mem_busy}, 32'h0);
    check("reset data_in", bus.dev_mem_data_in, 32'h0);
    check("reset ce_n", {31'h0, sram_ce_n}, 32'h1);
    check("reset oe_n", {31'h0, sram_oe_n}, 32'h1);
    check("reset we_n", {31'h0, sram_we_n}, 32'h1);
    check("reset data_oe", {31'h0, sram_data_oe}, 32'h0);
    check("reset sram_addr", 32'(sram_addr), 32'h0);
    check("reset sram_data_o", sram_data_o, 32'h0);
    #1 rst = 1'b1;

    // Directed: read, write then immediate read-back, out-of-range pair, cache sequence.
    do_access(32'h0000_0010, 32'h0, 1'b0);
    do_access(32'h0000_0008, 32'hDEAD_BEEF, 1'b1);
    do_access(32'h0000_0008, 32'h0, 1'b0);
    do_access(32'h8000_0000, 32'hCAFE_BABE, 1'b1);
    do_access(32'h8000_0000, 32'h0, 1'b0);
    do_access(32'h0000_0000, 32'h0, 1'b0);
    do_access(32'h0000_0020, 32'h0, 1'b0);
    do_access(32'h0000_0020, 32'h0, 1'b0);
    do_access(32'h0000_0040, $urandom, 1'b1);
    do_access(32'h0000_0020, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      w = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a[31:22] = 10'($urandom_range(1, 1023));
      do_access(a, $urandom, w);
    end

    // Reset in the middle of the write pulse must drop everything without a clock edge.
    do_access(32'h0000_03F0, 32'h55AA_55AA, 1'b1);
    guard = 0;
    while (sram_we_n !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("mid_write we_pulse_seen", {31'h0, sram_we_n}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("mid_write_reset we_n", {31'h0, sram_we_n}, 32'h1);
    check("mid_write_reset data_oe", {31'h0, sram_data_oe}, 32'h0);
    check("mid_write_reset busy", {31'h0, bus.dev_mem_busy}, 32'h0);
    check("mid_write_reset ce_n", {31'h0, sram_ce_n}, 32'h1);
    m_data_in = 0;
    m_valid   = 0;
    @(negedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      w = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 15) << 2);
      do_access(a, $urandom, w);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
